// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: program-loader state encoding, RAM size
// and the bit positions of the active-low control strobes.
package cpu_pkg;

  localparam int unsigned RAM_BYTES = 16;

  // Active-low control strobe positions, shared with the control block.
  localparam int unsigned CTRL_NLMA = 0;
  localparam int unsigned CTRL_NLMD = 1;
  localparam int unsigned CTRL_NLR  = 2;
  localparam int unsigned CTRL_W    = 3;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_WAIT_BYTE,
    LD_LOAD_ADDR,
    LD_LOAD_DATA,
    LD_WRITE,
    LD_DONE
  } loader_state_t;

  // States in which the loader owns the shared bus.
  function automatic logic drives_bus(input loader_state_t s);
    return (s == LD_LOAD_ADDR) || (s == LD_LOAD_DATA);
  endfunction

endpackage

// File: rtl/pin_sync.sv
// Multi-stage synchroniser for an asynchronous pin, with a registered-history
// rising-edge indication on the synchronised value.
module pin_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain[0] <= din;
      for (int unsigned i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;

endmodule

// File: rtl/program_loader.sv
// Host program-load stage: takes strobed bytes from the pins and writes them
// sequentially into RAM through the MAR/RAM strobes, holding the CPU meanwhile.
module program_loader
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_BYTES   = RAM_BYTES,
  parameter int unsigned ADDR_W      = $clog2(NUM_BYTES),
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       programming,
  input  logic       byte_strobe,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic       done_load,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       n_load_addr,
  output logic       n_load_data,
  output logic       n_ram_load,
  output logic       cpu_hold
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);

  loader_state_t     state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [7:0]        hold, hold_nx;
  logic [CTRL_W-1:0] ctrl_n;

  logic prog_sync, prog_rise_unused;
  logic strobe_sync_unused, strobe_rise;

  pin_sync #(.STAGES(SYNC_STAGES)) u_prog_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (programming),
    .sync  (prog_sync),
    .rise  (prog_rise_unused)
  );

  pin_sync #(.STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (byte_strobe),
    .sync  (strobe_sync_unused),
    .rise  (strobe_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LD_IDLE;
      addr  <= '0;
      hold  <= '0;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
      hold  <= hold_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    hold_nx  = hold;
    // Losing the host request overrides every other transition, including DONE exit.
    if (state != LD_IDLE && !prog_sync) begin
      state_nx = LD_IDLE;
      addr_nx  = '0;
    end else begin
      case (state)
        LD_IDLE: begin
          addr_nx = '0;
          if (prog_sync) state_nx = LD_WAIT_BYTE;
        end
        LD_WAIT_BYTE: begin
          if (strobe_rise) begin
            hold_nx  = data_in;
            state_nx = LD_LOAD_ADDR;
          end
        end
        LD_LOAD_ADDR: state_nx = LD_LOAD_DATA;
        LD_LOAD_DATA: state_nx = LD_WRITE;
        LD_WRITE: begin
          if (addr == LAST_ADDR) begin
            state_nx = LD_DONE;
          end else begin
            addr_nx  = addr + 1'b1;
            state_nx = LD_WAIT_BYTE;
          end
        end
        LD_DONE: state_nx = LD_DONE;
        default: begin
          state_nx = LD_IDLE;
          addr_nx  = '0;
        end
      endcase
    end
  end

  always_comb begin
    ctrl_n    = '1;
    bus_out   = '0;
    bus_oe    = drives_bus(state);
    ready     = (state == LD_WAIT_BYTE);
    done_load = (state == LD_DONE);
    cpu_hold  = (state != LD_IDLE);
    case (state)
      LD_LOAD_ADDR: begin
        bus_out           = 8'(addr);
        ctrl_n[CTRL_NLMA] = 1'b0;
      end
      LD_LOAD_DATA: begin
        bus_out           = hold;
        ctrl_n[CTRL_NLMD] = 1'b0;
      end
      LD_WRITE: ctrl_n[CTRL_NLR] = 1'b0;
      default: ;
    endcase
  end

  assign n_load_addr = ctrl_n[CTRL_NLMA];
  assign n_load_data = ctrl_n[CTRL_NLMD];
  assign n_ram_load  = ctrl_n[CTRL_NLR];

endmodule

// File: doc/program_loader.md
# program_loader

Upstream program-load stage for the 8-bit CPU. It accepts bytes from the host on `ui_in` under a pin-level strobe handshake and writes them sequentially into the 16-byte RAM. For each byte it drives the address and then the data onto the shared bus, pulsing the MAR address-load, MAR data-load and RAM-load strobes. While loading, it holds the CPU sequencer idle; when all bytes are written it reports `done_load` to the host.

## Interface
Parameters:
- `NUM_BYTES`, 16: number of RAM bytes loaded per session.
- `ADDR_W`, 4: address width, `$clog2(NUM_BYTES)`.
- `SYNC_STAGES`, 2: synchroniser depth on the asynchronous pin inputs.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `programming` input 1: host request to load (`uio_in[0]`), asynchronous.
- `byte_strobe` input 1: host byte-valid strobe (`uio_in[3]`), asynchronous; the rising edge is significant.
- `data_in` input 8: program byte (`ui_in`).
- `ready` output 1: loader waiting for the next byte (`uio_out[1]`).
- `done_load` output 1: all `NUM_BYTES` written (`uio_out[2]`).
- `bus_out` output 8: value to drive onto the bus.
- `bus_oe` output 1: bus drive enable, active-high; contributes to `outputting_to_bus`.
- `n_load_addr` output 1: MAR address load (nLma), active-low.
- `n_load_data` output 1: MAR data load (nLmd), active-low.
- `n_ram_load` output 1: RAM write (nLr), active-low.
- `cpu_hold` output 1: high whenever the loader is not IDLE; the control block freezes while it is high.

## Operation
Input conditioning:
- `programming` and `byte_strobe` each pass through a `SYNC_STAGES` flop chain.
- Strobe edge = synchronised value is 1 and the previous synchronised value is 0.

States:
- **IDLE**
  - All strobes high, `bus_oe` low, `ready` low, address counter at 0.
  - Synchronised `programming` = 1 → WAIT_BYTE.
- **WAIT_BYTE**
  - `ready` = 1.
  - On a strobe edge: capture `data_in` into the holding register → LOAD_ADDR.
- **LOAD_ADDR**
  - `bus_out` = {0, addr}, `bus_oe` = 1, `n_load_addr` = 0.
  - → LOAD_DATA.
- **LOAD_DATA**
  - `bus_out` = held byte, `bus_oe` = 1, `n_load_data` = 0.
  - → WRITE.
- **WRITE**
  - `n_ram_load` = 0, `bus_oe` = 0.
  - If addr = `NUM_BYTES`−1: → DONE.
  - Otherwise: addr += 1, → WAIT_BYTE.
- **DONE**
  - `done_load` = 1, `ready` = 0.
  - Held until synchronised `programming` = 0, then → IDLE and clear addr.

Boundary rules:
- **`programming` drops in any non-IDLE state:** go to IDLE on the next edge. All strobes return inactive that cycle, addr is cleared, and a write in flight is abandoned.
- **Strobe edge outside WAIT_BYTE:** ignored, not queued.
- **`programming` still high after DONE:** no reload. Re-arming requires `programming` to go low, then high.
- **Address counter:** `ADDR_W` bits wide and never wraps within a session; DONE is entered instead.
- **Strobe exclusivity:** at most one of `n_load_addr`, `n_load_data`, `n_ram_load` is low in any cycle.
- **Reset (asynchronous, any time):** state IDLE, addr 0, holding register 0, synchronisers 0. `ready`, `done_load`, `bus_oe` and `cpu_hold` are 0; all active-low strobes are 1; `bus_out` is 0.

## Timing
- All outputs are decoded from registered state and registered addr/holding data. There are no combinational input-to-output paths.
- Pin-to-edge detection latency: `SYNC_STAGES`+1 cycles.
- Host requirement: `data_in` stable from the `byte_strobe` rise until `ready` falls.
- Per-byte sequence, with the edge detected in cycle E:
  - E+1: LOAD_ADDR; `ready` falls.
  - E+2: LOAD_DATA.
  - E+3: WRITE.
  - E+4: WAIT_BYTE, `ready` = 1 (or DONE, `done_load` = 1, after the last byte).
- Minimum host strobe period: 4 + `SYNC_STAGES` + 1 cycles. The strobe low time must be at least `SYNC_STAGES`+1 cycles.

## Structure
- Shared package `cpu_pkg`:
  - Loader state enum.
  - `RAM_BYTES` = 16.
  - Control-strobe bit indices, which are also used by the control block.
- One sub-module, `pin_sync`: parameterised-depth synchroniser with a rising-edge output. It is instantiated twice, once for `programming` and once for `byte_strobe`.

## Test plan
- **Reset values:** assert `rst_n` = 0 mid-LOAD_DATA → all strobes go to 1, `bus_oe` 0, `ready` 0 without waiting for a clock edge; after release, state IDLE.
- **Single byte:** `programming` = 1; `data_in` = 0xA5 with a strobe rise → address 0x00 on the bus with `n_load_addr` low; next cycle 0xA5 with `n_load_data` low; next cycle `n_ram_load` low; `ready` returns 4 cycles after the edge.
- **Full load:** 16 bytes 0x10..0x1F → RAM[i] = 0x10+i, `done_load` = 1 after the 16th WRITE; `programming` low → IDLE, `done_load` 0, `cpu_hold` 0.
- **Abort:** drop `programming` after 5 bytes → IDLE within `SYNC_STAGES`+1 cycles, no further strobes; a new session starts at address 0.
- **Ignored strobe:** strobe pulse while in LOAD_ADDR → no extra byte written, addr advances by exactly 1.
- **Re-arm:** hold `programming` high in DONE with further strobes → no writes; low-then-high → WAIT_BYTE at address 0.
